// File: rtl/fwd_pkg.sv
// Shared encodings for the ID-stage operand forwarding and LOP scoreboard.
// Imported by the per-port mux and the scoreboard top.
package fwd_pkg;

  localparam logic [1:0] WB_NONE = 2'b00;
  localparam logic [1:0] WB_ALU  = 2'b01;
  localparam logic [1:0] WB_MEM  = 2'b10;
  localparam logic [1:0] WB_NPC  = 2'b11;

  typedef enum logic [2:0] {
    OP_RF,
    OP_LOP,
    OP_EXE,
    OP_MEM,
    OP_WB
  } op_sel_e;

endpackage

// File: rtl/fwd_mux.sv
// One source read port: bypass priority mux plus its
// load-use and RAW-on-LOP stall term.
module fwd_mux
  import fwd_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            id_valid_i,
  input  logic [AW-1:0]   src_i,
  input  logic            used_i,
  input  logic [XLEN-1:0] rf_data_i,
  input  logic [AW-1:0]   rd_exe_i,
  input  logic [AW-1:0]   rd_mem_i,
  input  logic [AW-1:0]   rd_wb_i,
  input  logic            we_exe_i,
  input  logic            we_mem_i,
  input  logic            we_wb_i,
  input  logic [1:0]      sel_exe_i,
  input  logic [1:0]      sel_mem_i,
  input  logic [XLEN-1:0] alu_exe_i,
  input  logic [XLEN-1:0] npc_exe_i,
  input  logic [XLEN-1:0] alu_mem_i,
  input  logic [XLEN-1:0] npc_mem_i,
  input  logic [XLEN-1:0] dmem_mem_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            lop_vld_i,
  input  logic [AW-1:0]   lop_rd_i,
  input  logic [XLEN-1:0] lop_data_i,
  input  logic [NREG-1:0] sb_busy_i,
  output logic [XLEN-1:0] data_o,
  output logic            stall_o
);

  logic            nz;
  logic            lop_hit;
  logic            exe_hit;
  logic            mem_hit;
  logic            wb_hit;
  logic            ld_use;
  logic            raw_lop;
  logic [XLEN-1:0] exe_val;
  logic [XLEN-1:0] mem_val;
  op_sel_e         sel;

  assign nz      = (src_i != '0);
  assign lop_hit = nz && lop_vld_i && (lop_rd_i == src_i);
  assign exe_hit = nz && we_exe_i && (rd_exe_i == src_i);
  assign mem_hit = nz && we_mem_i && (rd_mem_i == src_i);
  assign wb_hit  = nz && we_wb_i && (rd_wb_i == src_i);

  // A LOP result is always the youngest writer, so it outranks the pipe.
  always_comb begin
    if (lop_hit)      sel = OP_LOP;
    else if (exe_hit) sel = OP_EXE;
    else if (mem_hit) sel = OP_MEM;
    else if (wb_hit)  sel = OP_WB;
    else              sel = OP_RF;
  end

  always_comb begin
    exe_val = '0;
    unique case (sel_exe_i)
      WB_ALU:  exe_val = alu_exe_i;
      WB_NPC:  exe_val = npc_exe_i;
      default: exe_val = '0;
    endcase
  end

  always_comb begin
    mem_val = '0;
    unique case (sel_mem_i)
      WB_ALU:  mem_val = alu_mem_i;
      WB_MEM:  mem_val = dmem_mem_i;
      WB_NPC:  mem_val = npc_mem_i;
      default: mem_val = '0;
    endcase
  end

  always_comb begin
    data_o = rf_data_i;
    unique case (sel)
      OP_LOP:  data_o = lop_data_i;
      OP_EXE:  data_o = exe_val;
      OP_MEM:  data_o = mem_val;
      OP_WB:   data_o = wb_data_i;
      default: data_o = rf_data_i;
    endcase
  end

  assign ld_use  = exe_hit && (sel_exe_i == WB_MEM);
  assign raw_lop = sb_busy_i[src_i] && !lop_hit;
  assign stall_o = id_valid_i && used_i && (ld_use || raw_lop);

endmodule

// File: rtl/fwd_scoreboard_unit.sv
// ID-stage operand forwarding with a busy-bit scoreboard for the
// long-latency (mul/div) unit and the resulting ID stall.
module fwd_scoreboard_unit
  import fwd_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int NRP     = 2,
  parameter int NREG    = 32,
  parameter int MAX_LOP = 4,
  parameter int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [NRP*AW-1:0]   rs_addr,
  input  logic [NRP-1:0]      rs_used,
  input  logic [NRP*XLEN-1:0] rs_data_rf,
  input  logic [AW-1:0]       id_rd,
  input  logic                id_we,
  input  logic                id_is_lop,
  input  logic [AW-1:0]       rd_addr_exe,
  input  logic [AW-1:0]       rd_addr_mem,
  input  logic [AW-1:0]       rd_addr_wb,
  input  logic                we_reg_exe,
  input  logic                we_reg_mem,
  input  logic                we_reg_wb,
  input  logic [1:0]          wb_sel_exe,
  input  logic [1:0]          wb_sel_mem,
  input  logic [XLEN-1:0]     alu_res_exe,
  input  logic [XLEN-1:0]     npc_exe,
  input  logic [XLEN-1:0]     alu_res_mem,
  input  logic [XLEN-1:0]     npc_mem,
  input  logic [XLEN-1:0]     dmem_mem,
  input  logic [XLEN-1:0]     rd_data_wb,
  input  logic                lop_done_valid,
  input  logic [AW-1:0]       lop_done_rd,
  input  logic [XLEN-1:0]     lop_done_data,
  output logic [NRP*XLEN-1:0] rs_data_fwd,
  output logic                stall_id,
  output logic                lop_issue,
  output logic [NREG-1:0]     sb_busy,
  output logic [31:0]         stall_cnt,
  output logic                sb_err
);

  localparam int OW = $clog2(MAX_LOP + 1);

  logic [NREG-1:0] busy_q, busy_d;
  logic [OW-1:0]   out_q, out_d;
  logic [31:0]     cnt_q, cnt_d;
  logic            err_q, err_d;

  logic [NRP-1:0]  port_stall;
  logic            done_on_rd;
  logic            waw;
  logic            lop_full;
  logic            dec_at_zero;

  for (genvar i = 0; i < NRP; i++) begin : g_port
    fwd_mux #(
      .XLEN (XLEN),
      .NREG (NREG),
      .AW   (AW)
    ) u_mux (
      .id_valid_i (id_valid),
      .src_i      (rs_addr[i*AW +: AW]),
      .used_i     (rs_used[i]),
      .rf_data_i  (rs_data_rf[i*XLEN +: XLEN]),
      .rd_exe_i   (rd_addr_exe),
      .rd_mem_i   (rd_addr_mem),
      .rd_wb_i    (rd_addr_wb),
      .we_exe_i   (we_reg_exe),
      .we_mem_i   (we_reg_mem),
      .we_wb_i    (we_reg_wb),
      .sel_exe_i  (wb_sel_exe),
      .sel_mem_i  (wb_sel_mem),
      .alu_exe_i  (alu_res_exe),
      .npc_exe_i  (npc_exe),
      .alu_mem_i  (alu_res_mem),
      .npc_mem_i  (npc_mem),
      .dmem_mem_i (dmem_mem),
      .wb_data_i  (rd_data_wb),
      .lop_vld_i  (lop_done_valid),
      .lop_rd_i   (lop_done_rd),
      .lop_data_i (lop_done_data),
      .sb_busy_i  (busy_q),
      .data_o     (rs_data_fwd[i*XLEN +: XLEN]),
      .stall_o    (port_stall[i])
    );
  end

  assign done_on_rd = lop_done_valid && (lop_done_rd == id_rd);

  assign waw = id_valid && id_we && busy_q[id_rd] && !done_on_rd;

  // A completion this cycle frees a slot, so a full queue can still issue.
  assign lop_full = id_valid && id_is_lop
                 && (out_q == OW'(MAX_LOP)) && !lop_done_valid;

  assign stall_id = (|port_stall) || waw || lop_full;

  assign lop_issue = id_valid && id_is_lop && id_we
                  && (id_rd != '0) && !stall_id;

  assign dec_at_zero = lop_done_valid && !lop_issue && (out_q == '0);

  always_comb begin
    busy_d = busy_q;
    if (lop_done_valid) busy_d[lop_done_rd] = 1'b0;
    if (lop_issue)      busy_d[id_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    out_d = out_q;
    if (lop_issue && !lop_done_valid) begin
      out_d = out_q + OW'(1);
    end else if (lop_done_valid && !lop_issue && (out_q != '0)) begin
      out_d = out_q - OW'(1);
    end
  end

  always_comb begin
    err_d = err_q;
    if (lop_done_valid && !busy_q[lop_done_rd]) err_d = 1'b1;
    if (dec_at_zero) err_d = 1'b1;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_id && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      out_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  assign sb_busy   = busy_q;
  assign stall_cnt = cnt_q;
  assign sb_err    = err_q;

endmodule

// File: tb/tb_fwd_scoreboard_unit.sv
// Scoreboard-queue bench for fwd_scoreboard_unit: expectations are
// queued as stimulus is driven and popped when outputs are sampled.
module tb_fwd_scoreboard_unit;

  localparam int XLEN = 64;
  localparam int NRP  = 2;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic                clk;
  logic                rst;
  logic                id_valid;
  logic [NRP*AW-1:0]   rs_addr;
  logic [NRP-1:0]      rs_used;
  logic [NRP*XLEN-1:0] rs_data_rf;
  logic [AW-1:0]       id_rd;
  logic                id_we;
  logic                id_is_lop;
  logic [AW-1:0]       rd_addr_exe, rd_addr_mem, rd_addr_wb;
  logic                we_reg_exe, we_reg_mem, we_reg_wb;
  logic [1:0]          wb_sel_exe, wb_sel_mem;
  logic [XLEN-1:0]     alu_res_exe, npc_exe, alu_res_mem;
  logic [XLEN-1:0]     npc_mem, dmem_mem, rd_data_wb;
  logic                lop_done_valid;
  logic [AW-1:0]       lop_done_rd;
  logic [XLEN-1:0]     lop_done_data;
  logic [NRP*XLEN-1:0] rs_data_fwd;
  logic                stall_id;
  logic                lop_issue;
  logic [NREG-1:0]     sb_busy;
  logic [31:0]         stall_cnt;
  logic                sb_err;

  int checks = 0;
  int errors = 0;

  typedef enum int {S_RS0, S_RS1, S_STALL, S_ISSUE, S_BUSY, S_CNT, S_ERR} sig_e;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [63:0] val;
  } exp_t;

  exp_t sbq[$];

  logic [31:0] exp_busy;
  int          exp_cnt;

  fwd_scoreboard_unit #(
    .XLEN    (XLEN),
    .NRP     (NRP),
    .NREG    (NREG),
    .MAX_LOP (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .rs_addr        (rs_addr),
    .rs_used        (rs_used),
    .rs_data_rf     (rs_data_rf),
    .id_rd          (id_rd),
    .id_we          (id_we),
    .id_is_lop      (id_is_lop),
    .rd_addr_exe    (rd_addr_exe),
    .rd_addr_mem    (rd_addr_mem),
    .rd_addr_wb     (rd_addr_wb),
    .we_reg_exe     (we_reg_exe),
    .we_reg_mem     (we_reg_mem),
    .we_reg_wb      (we_reg_wb),
    .wb_sel_exe     (wb_sel_exe),
    .wb_sel_mem     (wb_sel_mem),
    .alu_res_exe    (alu_res_exe),
    .npc_exe        (npc_exe),
    .alu_res_mem    (alu_res_mem),
    .npc_mem        (npc_mem),
    .dmem_mem       (dmem_mem),
    .rd_data_wb     (rd_data_wb),
    .lop_done_valid (lop_done_valid),
    .lop_done_rd    (lop_done_rd),
    .lop_done_data  (lop_done_data),
    .rs_data_fwd    (rs_data_fwd),
    .stall_id       (stall_id),
    .lop_issue      (lop_issue),
    .sb_busy        (sb_busy),
    .stall_cnt      (stall_cnt),
    .sb_err         (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] obs(input sig_e s);
    case (s)
      S_RS0:   return rs_data_fwd[63:0];
      S_RS1:   return rs_data_fwd[127:64];
      S_STALL: return 64'(stall_id);
      S_ISSUE: return 64'(lop_issue);
      S_BUSY:  return 64'(sb_busy);
      S_CNT:   return 64'(stall_cnt);
      S_ERR:   return 64'(sb_err);
      default: return '0;
    endcase
  endfunction

  task automatic push(input string n, input sig_e s, input logic [63:0] v);
    exp_t e;
    e.name = n;
    e.sig  = s;
    e.val  = v;
    sbq.push_back(e);
  endtask

  task automatic clr();
    id_valid = 0; rs_addr = '0; rs_used = '0; rs_data_rf = '0;
    id_rd = '0; id_we = 0; id_is_lop = 0;
    rd_addr_exe = '0; rd_addr_mem = '0; rd_addr_wb = '0;
    we_reg_exe = 0; we_reg_mem = 0; we_reg_wb = 0;
    wb_sel_exe = 2'b00; wb_sel_mem = 2'b00;
    alu_res_exe = '0; npc_exe = '0; alu_res_mem = '0;
    npc_mem = '0; dmem_mem = '0; rd_data_wb = '0;
    lop_done_valid = 0; lop_done_rd = '0; lop_done_data = '0;
  endtask

  task automatic test_reset();
    exp_t e;
    clr();
    rst = 1;
    exp_busy = '0;
    exp_cnt = 0;
    @(posedge clk); #1;
    push("rst_busy", S_BUSY, 64'd0);
    push("rst_cnt", S_CNT, 64'd0);
    push("rst_err", S_ERR, 64'd0);
    push("rst_stall", S_STALL, 64'd0);
    @(negedge clk);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); checks++;
      if (obs(e.sig) !== e.val) begin
        errors++;
        $display("FAIL %s got %0h want %0h", e.name, obs(e.sig), e.val);
      end
    end
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_forward();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      clr();
      id_valid = 1;
      rs_used = 2'b11;
      case (c)
        0: begin
          rs_addr[4:0] = 5; rs_addr[9:5] = 6;
          rs_data_rf[63:0] = 64'h11; rs_data_rf[127:64] = 64'h22;
          we_reg_exe = 1; rd_addr_exe = 5; wb_sel_exe = 2'b01;
          alu_res_exe = 64'hAA;
          we_reg_mem = 1; rd_addr_mem = 5; wb_sel_mem = 2'b01;
          alu_res_mem = 64'hBB;
          we_reg_wb = 1; rd_addr_wb = 6; rd_data_wb = 64'hCC;
          push("fwd_exe_over_mem", S_RS0, 64'hAA);
          push("fwd_wb", S_RS1, 64'hCC);
        end
        1: begin
          rs_addr[4:0] = 5; rs_addr[9:5] = 6;
          rs_data_rf[63:0] = 64'h11; rs_data_rf[127:64] = 64'h22;
          we_reg_mem = 1; rd_addr_mem = 5; wb_sel_mem = 2'b01;
          alu_res_mem = 64'hBB;
          we_reg_wb = 1; rd_addr_wb = 5; rd_data_wb = 64'hDD;
          push("fwd_mem_over_wb", S_RS0, 64'hBB);
          push("fwd_rf", S_RS1, 64'h22);
        end
        2: begin
          rs_addr[4:0] = 5; rs_addr[9:5] = 0;
          we_reg_exe = 1; rd_addr_exe = 5; wb_sel_exe = 2'b11;
          npc_exe = 64'hE0; alu_res_exe = 64'hAA;
          we_reg_wb = 1; rd_addr_wb = 0; rd_data_wb = 64'hFF;
          push("fwd_exe_npc", S_RS0, 64'hE0);
          push("fwd_r0_never", S_RS1, 64'h0);
        end
        default: begin
          rs_addr[4:0] = 5; rs_addr[9:5] = 5;
          we_reg_exe = 1; rd_addr_exe = 5; wb_sel_exe = 2'b00;
          alu_res_exe = 64'hAA;
          we_reg_mem = 1; rd_addr_mem = 5; wb_sel_mem = 2'b10;
          dmem_mem = 64'h5555;
          push("fwd_exe_none_zero", S_RS0, 64'h0);
          push("fwd_exe_none_zero_p1", S_RS1, 64'h0);
        end
      endcase
      push("fwd_no_stall", S_STALL, 64'd0);
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); checks++;
        if (obs(e.sig) !== e.val) begin
          errors++;
          $display("FAIL %s c%0d got %0h want %0h", e.name, c, obs(e.sig), e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      clr();
      id_valid = 1;
      case (c)
        0: begin
          rs_addr[4:0] = 7; rs_used = 2'b01;
          we_reg_exe = 1; rd_addr_exe = 7; wb_sel_exe = 2'b10;
          alu_res_exe = 64'h999;
          push("lu_stall", S_STALL, 64'd1);
          exp_cnt++;
        end
        1: begin
          rs_addr[4:0] = 7; rs_used = 2'b01;
          we_reg_mem = 1; rd_addr_mem = 7; wb_sel_mem = 2'b10;
          dmem_mem = 64'h1234;
          push("lu_fwd_dmem", S_RS0, 64'h1234);
          push("lu_released", S_STALL, 64'd0);
          push("lu_cnt", S_CNT, 64'(exp_cnt));
        end
        2: begin
          rs_addr[4:0] = 7; rs_used = 2'b00;
          we_reg_exe = 1; rd_addr_exe = 7; wb_sel_exe = 2'b10;
          push("lu_unused_port", S_STALL, 64'd0);
        end
        default: begin
          rs_addr[4:0] = 0; rs_used = 2'b01;
          we_reg_exe = 1; rd_addr_exe = 0; wb_sel_exe = 2'b10;
          push("lu_r0", S_STALL, 64'd0);
        end
      endcase
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); checks++;
        if (obs(e.sig) !== e.val) begin
          errors++;
          $display("FAIL %s got %0h want %0h", e.name, obs(e.sig), e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_raw_lop();
    exp_t e;
    for (int c = 0; c < 8; c++) begin
      clr();
      if (c == 0) begin
        id_valid = 1; id_is_lop = 1; id_we = 1; id_rd = 9;
        push("raw_issue", S_ISSUE, 64'd1);
        push("raw_issue_nostall", S_STALL, 64'd0);
        exp_busy[9] = 1'b1;
      end else if (c <= 4) begin
        id_valid = 1; rs_addr[9:5] = 9; rs_used = 2'b10;
        rs_data_rf[127:64] = 64'h3;
        push("raw_busy", S_BUSY, 64'(exp_busy));
        push("raw_stall", S_STALL, 64'd1);
        push("raw_no_issue", S_ISSUE, 64'd0);
        exp_cnt++;
      end else if (c == 5) begin
        id_valid = 1; id_we = 1; id_rd = 9;
        push("waw_stall", S_STALL, 64'd1);
        exp_cnt++;
      end else if (c == 6) begin
        id_valid = 1; rs_addr[9:5] = 9; rs_used = 2'b10;
        rs_data_rf[127:64] = 64'h3;
        lop_done_valid = 1; lop_done_rd = 9; lop_done_data = 64'h77;
        push("raw_done_fwd", S_RS1, 64'h77);
        push("raw_done_nostall", S_STALL, 64'd0);
        exp_busy[9] = 1'b0;
      end else begin
        push("raw_cleared", S_BUSY, 64'(exp_busy));
        push("raw_cnt", S_CNT, 64'(exp_cnt));
        push("raw_no_err", S_ERR, 64'd0);
      end
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); checks++;
        if (obs(e.sig) !== e.val) begin
          errors++;
          $display("FAIL %s c%0d got %0h want %0h", e.name, c, obs(e.sig), e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_lop_full();
    exp_t e;
    for (int c = 0; c < 12; c++) begin
      clr();
      if (c < 4) begin
        id_valid = 1; id_is_lop = 1; id_we = 1; id_rd = AW'(10 + c);
        push("full_fill_issue", S_ISSUE, 64'd1);
        exp_busy[10 + c] = 1'b1;
      end else if (c == 4) begin
        id_valid = 1; id_is_lop = 1; id_we = 1; id_rd = 14;
        push("full_stall", S_STALL, 64'd1);
        push("full_no_issue", S_ISSUE, 64'd0);
        push("full_busy4", S_BUSY, 64'(exp_busy));
        exp_cnt++;
      end else if (c == 5) begin
        id_valid = 1; id_is_lop = 1; id_we = 1; id_rd = 14;
        lop_done_valid = 1; lop_done_rd = 10; lop_done_data = 64'h1;
        push("full_done_issue", S_ISSUE, 64'd1);
        push("full_done_nostall", S_STALL, 64'd0);
        exp_busy[10] = 1'b0;
        exp_busy[14] = 1'b1;
      end else if (c == 6) begin
        id_valid = 1; id_is_lop = 1; id_we = 1; id_rd = 15;
        push("full_still4_stall", S_STALL, 64'd1);
        push("full_still4_noiss", S_ISSUE, 64'd0);
        push("full_swap_busy", S_BUSY, 64'(exp_busy));
        exp_cnt++;
      end else if (c < 11) begin
        lop_done_valid = 1; lop_done_rd = AW'(c + 4);
        exp_busy[c + 4] = 1'b0;
      end else begin
        push("full_drained", S_BUSY, 64'(exp_busy));
        push("full_no_err", S_ERR, 64'd0);
        push("full_cnt", S_CNT, 64'(exp_cnt));
      end
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); checks++;
        if (obs(e.sig) !== e.val) begin
          errors++;
          $display("FAIL %s c%0d got %0h want %0h", e.name, c, obs(e.sig), e.val);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_err_reset();
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      clr();
      case (c)
        0: begin
          lop_done_valid = 1; lop_done_rd = 3; lop_done_data = 64'h5;
        end
        1: push("err_set", S_ERR, 64'd1);
        2: begin
          push("err_held", S_ERR, 64'd1);
          id_valid = 1; id_is_lop = 1; id_we = 1; id_rd = 20;
          push("err_lop_issue", S_ISSUE, 64'd1);
          exp_busy[20] = 1'b1;
        end
        default: begin
          id_valid = 1; rs_addr[4:0] = 20; rs_used = 2'b01;
          push("pre_rst_stall", S_STALL, 64'd1);
          push("pre_rst_busy", S_BUSY, 64'(exp_busy));
          push("pre_rst_cnt", S_CNT, 64'(exp_cnt));
        end
      endcase
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front(); checks++;
        if (obs(e.sig) !== e.val) begin
          errors++;
          $display("FAIL %s got %0h want %0h", e.name, obs(e.sig), e.val);
        end
      end
      if (c < 3) begin
        @(posedge clk); #1;
      end
    end
    // Reset lands mid-cycle, well before the next rising edge.
    #1;
    rst = 1;
    exp_busy = '0;
    exp_cnt = 0;
    #1;
    push("async_rst_busy", S_BUSY, 64'd0);
    push("async_rst_cnt", S_CNT, 64'd0);
    push("async_rst_err", S_ERR, 64'd0);
    push("async_rst_stall", S_STALL, 64'd0);
    while (sbq.size() > 0) begin
      e = sbq.pop_front(); checks++;
      if (obs(e.sig) !== e.val) begin
        errors++;
        $display("FAIL %s got %0h want %0h", e.name, obs(e.sig), e.val);
      end
    end
    @(posedge clk); #1;
    clr();
    rst = 0;
  endtask

  initial begin
    rst = 1;
    clr();
    test_reset();
    test_forward();
    test_load_use();
    test_raw_lop();
    test_lop_full();
    test_err_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard_unit.md
Name: fwd_scoreboard_unit

Overview:
Parametrised successor to the ID-stage forwarding unit. Serves NRP source-register read ports with EXE/MEM/WB bypassing, plus a busy-bit scoreboard for an out-of-pipe long-latency unit (LOP: mul/div). Generates the ID stall for three cases: load-use, a source register awaiting a LOP result, and WAW hazards against LOP writes. Sits between the ID stage, the register file and the hazard/stall control.

Parameters:
XLEN, 64, datapath width
NRP, 2, number of source read ports
NREG, 32, architectural registers; AW = $clog2(NREG) is derived
MAX_LOP, 4, maximum outstanding LOP operations (≥1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID holds a valid instruction
rs_addr  in  NRP*AW  source addresses, port i at [i*AW +: AW]
rs_used  in  NRP  port i is actually read by the instruction
rs_data_rf  in  NRP*XLEN  register-file read data
id_rd  in  AW  ID destination register
id_we  in  1  ID instruction writes id_rd
id_is_lop  in  1  ID instruction issues to LOP
rd_addr_exe, rd_addr_mem, rd_addr_wb  in  AW  each  stage destinations
we_reg_exe, we_reg_mem, we_reg_wb  in  1  each  stage write enables
wb_sel_exe, wb_sel_mem  in  2  each  00 none, 01 alu, 10 dmem, 11 npc
alu_res_exe, npc_exe, alu_res_mem, npc_mem, dmem_mem, rd_data_wb  in  XLEN  each  bypass sources
lop_done_valid  in  1  LOP result writes back this cycle
lop_done_rd  in  AW  LOP result register
lop_done_data  in  XLEN  LOP result
rs_data_fwd  out  NRP*XLEN  forwarded operands
stall_id  out  1  hold ID/IF, insert bubble into EXE
lop_issue  out  1  LOP issue accepted this cycle
sb_busy  out  NREG  scoreboard busy bits
stall_cnt  out  32  saturating count of stalled cycles
sb_err  out  1  sticky flag: completion for a register not marked busy

Behaviour:
- Reset (async, rst=1): sb_busy=0, outstanding=0, stall_cnt=0, sb_err=0. Combinational outputs follow from the cleared state.
- Register 0 is never forwarded and never marked busy; a source on r0 yields rs_data_rf (0).
- Per-port operand priority, combinational, 0-cycle latency:
  1. lop_done_valid && lop_done_rd==src
  2. EXE: we_reg_exe, match, wb_sel 01→alu_res_exe, 11→npc_exe, 00→0
  3. MEM: wb_sel 01 alu, 10 dmem, 11 npc, 00 0
  4. WB: rd_data_wb
  5. rs_data_rf
- LOP latency is ≥3 cycles, so the LOP result is always the youngest writer.
- Stall terms, each gated by id_valid:
  - load-use: rs_used[i] && we_reg_exe && wb_sel_exe==10 && rd_addr_exe==src, src≠0.
  - RAW-LOP: rs_used[i] && sb_busy[src] && !(lop_done_valid && lop_done_rd==src).
  - WAW: id_we && sb_busy[id_rd] && !(lop_done_valid && lop_done_rd==id_rd).
  - LOP full: id_is_lop && outstanding==MAX_LOP && !lop_done_valid.
- stall_id = OR of all stall terms.
- lop_issue = id_valid && id_is_lop && id_we && id_rd≠0 && !stall_id.
- Sequential updates, rising clk:
  - On lop_issue: sb_busy[id_rd] set.
  - On lop_done_valid: sb_busy[lop_done_rd] cleared.
  - Same register issued and done in the same cycle: set wins.
  - outstanding += lop_issue − lop_done_valid. Simultaneous issue+done leaves it unchanged. Decrement at 0 does not wrap; it sets sb_err.
  - lop_done_valid with sb_busy[lop_done_rd]==0 sets sb_err, which holds until reset.
  - stall_cnt increments while stall_id=1 and saturates at 32'hFFFF_FFFF.
- Pipeline flushes do not touch the scoreboard: issued LOPs always complete.

Decomposition:
- Shared package fwd_pkg: wb_sel encodings (WB_NONE, WB_ALU, WB_MEM, WB_NPC) and the operand-select enum.
- Sub-module fwd_mux: one read port's priority mux plus its load-use/RAW-LOP stall term. Instantiated NRP times with a generate loop.

Test Plan:
- EXE alu writes x5=0xAA, MEM writes x5=0xBB, rs port0=x5 → rs_data_fwd[0]=0xAA, stall_id=0.
- EXE load to x7 (wb_sel 10), ID reads x7 → stall_id=1 for 1 cycle; next cycle with the load in MEM and dmem_mem=0x1234 → forwarded 0x1234, stall_id=0, stall_cnt=1.
- LOP issue to x9; ID reads x9 for 4 cycles → stall_id=1 each cycle. Then lop_done x9, data 0x77 → same cycle forward 0x77, stall_id=0, sb_busy[9]=0.
- Issue MAX_LOP=4 LOPs, a 5th LOP in ID → stall_id=1. lop_done in the same cycle → 5th issues, outstanding stays 4.
- lop_done_valid on x3 when not busy → sb_err=1 and held; assert rst mid-stall → sb_busy=0, stall_cnt=0, sb_err=0 immediately, without waiting for a clock.
